product_accumulator: RTL

Downstream stage of the 1024-lane multiplier array. It takes the registered vector of 1024 signed 17-bit products, one vector per weight tap, and sums them lane-wise over a programmable number of taps. It then saturates each sum back to 17 bits and presents the result vector to the next stage (activation / output buffer) behind a valid/ready handshake. Sequential content: accumulator bank, tap counter, 3-state FSM and output hold register.

---
 rtl/product_accumulator.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/product_accumulator.sv
// Lane-wise accumulator for the multiplier array: sums T product vectors per lane, saturates
// each sum to OUT_WIDTH and holds the result vector behind a valid/ready handshake.
module product_accumulator #(
  parameter int unsigned LANES           = 1024,
  parameter int unsigned PRODUCT_WIDTH   = 17,
  parameter int unsigned ACC_WIDTH       = 24,
  parameter int unsigned OUT_WIDTH       = 17,
  parameter int unsigned TAP_COUNT_WIDTH = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*PRODUCT_WIDTH-1:0]   product,
  input  logic [TAP_COUNT_WIDTH-1:0]       taps,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*OUT_WIDTH-1:0]       result,
  output logic                             overflow,
  output logic                             busy
);

  localparam int SatMaxInt = (2 ** (OUT_WIDTH - 1)) - 1;
  localparam logic signed [ACC_WIDTH-1:0] SatMax = ACC_WIDTH'(SatMaxInt);
  localparam logic signed [ACC_WIDTH-1:0] SatMin = ACC_WIDTH'(-SatMaxInt - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

  state_e                       state_q, state_d;
  logic [TAP_COUNT_WIDTH-1:0]   count_q, count_d;
  logic [TAP_COUNT_WIDTH-1:0]   taps_q, taps_d;
  logic signed [ACC_WIDTH-1:0]  acc_q [LANES];
  logic signed [ACC_WIDTH-1:0]  acc_d [LANES];
  logic [LANES*OUT_WIDTH-1:0]   result_q, result_d;
  logic                         overflow_q, overflow_d;

  logic                         beat;
  logic                         load_result;
  logic [TAP_COUNT_WIDTH-1:0]   taps_eff;
  logic [TAP_COUNT_WIDTH-1:0]   count_inc;
  logic signed [ACC_WIDTH-1:0]  lane_sum [LANES];
  logic [LANES*OUT_WIDTH-1:0]   lane_sat;
  logic [LANES-1:0]             lane_ovf;

  // in_ready must not look at in_valid, only at state and reset.
  assign in_ready  = ~reset & (state_q != StHold);
  assign beat      = in_valid & in_ready;
  assign taps_eff  = (taps == '0) ? TAP_COUNT_WIDTH'(1) : taps;
  assign count_inc = count_q + 1'b1;

  assign out_valid = (state_q == StHold);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;
  assign overflow  = overflow_q;

  // The first beat of a batch starts from zero, so IDLE masks the stale accumulator.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [PRODUCT_WIDTH-1:0] prod_lane;
    logic signed [ACC_WIDTH-1:0]     acc_base;
    logic                            sat_hi;
    logic                            sat_lo;

    assign prod_lane   = product[i*PRODUCT_WIDTH +: PRODUCT_WIDTH];
    assign acc_base    = (state_q == StIdle) ? '0 : acc_q[i];
    assign lane_sum[i] = acc_base + ACC_WIDTH'(prod_lane);
    assign sat_hi      = (lane_sum[i] > SatMax);
    assign sat_lo      = (lane_sum[i] < SatMin);
    assign lane_ovf[i] = sat_hi | sat_lo;
    assign lane_sat[i*OUT_WIDTH +: OUT_WIDTH] = sat_hi ? SatMax[OUT_WIDTH-1:0] :
                                                sat_lo ? SatMin[OUT_WIDTH-1:0] :
                                                         lane_sum[i][OUT_WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    taps_d      = taps_q;
    acc_d       = acc_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    load_result = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (beat) begin
          acc_d   = lane_sum;
          taps_d  = taps_eff;
          count_d = TAP_COUNT_WIDTH'(1);
          if (taps_eff == TAP_COUNT_WIDTH'(1)) begin
            load_result = 1'b1;
            state_d     = StHold;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        if (beat) begin
          acc_d   = lane_sum;
          count_d = count_inc;
          if (count_inc == taps_q) begin
            load_result = 1'b1;
            state_d     = StHold;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_result) begin
      result_d   = lane_sat;
      overflow_d = |lane_ovf;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      taps_q     <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      taps_q     <= taps_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      acc_q      <= acc_d;
    end
  end

endmodule
